// File: rtl/noc_transceiver.sv
// Output stage of a router node: pops one packet from the node FIFO, routes it through
// the table RT_TABLE and holds it on the selected output port until the receiver takes it.
//   state | meaning
//   IDLE  | waiting for a non-empty FIFO
//   READ  | read request issued, FIFO data arrives next cycle
//   LOAD  | sample packet, drop if invalid, else route and present it
//   SEND  | holding packet on port p until r_ready_in[p]
module noc_transceiver #(
  parameter int DATA_SIZE = 4,
  parameter int ADDR_SIZE = 1,
  parameter int NODES_NUM = 4,
  localparam int BUS = DATA_SIZE + ADDR_SIZE + 1,
  localparam int PW  = $clog2(NODES_NUM + 1),
  // routing ROM, entry k at [k*PW +: PW]; default maps addr0->4, addr1->1
  parameter logic [PW*(2**ADDR_SIZE)-1:0] RT_TABLE = {3'd1, 3'd4}
) (
  input  logic                         clk,
  input  logic                         a_rst,
  input  logic                         empty,
  input  logic [NODES_NUM:0]           r_ready_in,
  input  logic [BUS-1:0]               data_i,
  output logic                         r_req,
  output logic [NODES_NUM:0]           wr_ready_out,
  output logic [BUS*(NODES_NUM+1)-1:0] data_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t r_state;

  logic [ADDR_SIZE-1:0]         w_addr;
  logic [PW-1:0]                w_rt_entry;
  logic [PW-1:0]                w_port;
  logic [NODES_NUM:0]           w_onehot;
  logic [BUS*(NODES_NUM+1)-1:0] w_slot;
  logic                         w_accept;

  always_comb begin
    w_addr     = data_i[BUS-2:DATA_SIZE];
    w_rt_entry = '0;
    for (int i = 0; i < 2**ADDR_SIZE; i++) begin
      if (w_addr == ADDR_SIZE'(i)) w_rt_entry = RT_TABLE[i*PW +: PW];
    end
    // out-of-range table entries fall back to the local port
    w_port   = (w_rt_entry > PW'(NODES_NUM)) ? PW'(NODES_NUM) : w_rt_entry;
    w_onehot = '0;
    w_slot   = '0;
    for (int i = 0; i <= NODES_NUM; i++) begin
      if (w_port == PW'(i)) begin
        w_onehot[i]          = 1'b1;
        w_slot[i*BUS +: BUS] = data_i;
      end
    end
  end

  // wr_ready_out is one-hot in SEND, so this only sees the selected port's ready
  assign w_accept = |(r_ready_in & wr_ready_out);

  always_ff @(posedge clk) begin
    if (a_rst) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      wr_ready_out <= '0;
      data_o       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!empty) begin
            r_req   <= 1'b1;
            r_state <= READ;
          end
        end
        READ: begin
          r_req   <= 1'b0;
          r_state <= LOAD;
        end
        LOAD: begin
          if (data_i[BUS-1]) begin
            data_o       <= w_slot;
            wr_ready_out <= w_onehot;
            r_state      <= SEND;
          end else begin
            r_state <= IDLE;
          end
        end
        SEND: begin
          if (w_accept) begin
            data_o       <= '0;
            wr_ready_out <= '0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_transceiver.sv
// Scoreboard bench for noc_transceiver: expected port/slice pushed when a packet is offered,
// popped when a new packet appears on the outputs.
module tb_noc_transceiver;

  localparam int BUS = 6;
  localparam int NP  = 5;

  logic              clk;
  logic              a_rst;
  logic              empty;
  logic [NP-1:0]     r_ready_in;
  logic [BUS-1:0]    data_i;
  logic              r_req;
  logic [NP-1:0]     wr_ready_out;
  logic [BUS*NP-1:0] data_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [NP+BUS*NP-1:0] sb_q[$];
  logic [NP-1:0]        prev_wr;
  int                   t1, t2;

  noc_transceiver dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .empty        (empty),
    .r_ready_in   (r_ready_in),
    .data_i       (data_i),
    .r_req        (r_req),
    .wr_ready_out (wr_ready_out),
    .data_o       (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference routing: addr0->4, addr1->1
  function automatic int ref_port(input logic [BUS-1:0] pkt);
    int rt [2];
    rt[0] = 4;
    rt[1] = 1;
    return (rt[pkt[4]] > 4) ? 4 : rt[pkt[4]];
  endfunction

  function automatic logic [NP+BUS*NP-1:0] ref_entry(input logic [BUS-1:0] pkt);
    logic [NP-1:0]     oh;
    logic [BUS*NP-1:0] d;
    oh = '0;
    oh[ref_port(pkt)] = 1'b1;
    d = '0;
    d[ref_port(pkt)*BUS +: BUS] = pkt;
    return {oh, d};
  endfunction

  // scoreboard monitor: a packet appears when wr_ready_out rises from zero
  always @(negedge clk) begin
    if (a_rst) begin
      prev_wr <= '0;
    end else begin
      if (wr_ready_out != '0 && prev_wr == '0) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected", {29'd0, wr_ready_out, data_o}, 64'd0);
        end else begin
          chk("sb_pkt", {29'd0, wr_ready_out, data_o}, {29'd0, sb_q.pop_front()});
        end
      end
      prev_wr <= wr_ready_out;
    end
  end

  task automatic wait_req();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!r_req && n < 20);
    if (!r_req) chk("req_timeout", 64'(r_req), 64'd1);
  endtask

  task automatic send_pkt(input logic [BUS-1:0] pkt, input logic [NP-1:0] rdy);
    data_i     = pkt;
    r_ready_in = rdy;
    if (pkt[BUS-1]) sb_q.push_back(ref_entry(pkt));
    empty = 1'b0;
    wait_req();
    empty = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"},  64'(r_req), 64'd0);
    chk({tag, "_wr"},   64'(wr_ready_out), 64'd0);
    chk({tag, "_data"}, 64'(data_o), 64'd0);
  endtask

  initial begin
    a_rst      = 1'b1;
    empty      = 1'b0;
    r_ready_in = '0;
    data_i     = '0;

    // reset holds everything at zero even with a non-empty FIFO
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_zero("reset");
    end
    a_rst = 1'b0;
    empty = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_zero("idle");
    end

    // local delivery
    send_pkt(6'b1_0_1010, 5'b11111);
    @(negedge clk);
    chk("loc_req_pulse", 64'(r_req), 64'd0);
    chk("loc_wr_early", 64'(wr_ready_out), 64'd0);
    @(negedge clk);
    chk("loc_wr", 64'(wr_ready_out), 64'b10000);
    chk("loc_slice4", 64'(data_o[4*BUS +: BUS]), 64'b101010);
    @(negedge clk);
    chk_zero("loc_clear");

    // backpressure on port 1; other ports' ready and a non-empty FIFO must not matter
    send_pkt(6'b1_1_0110, 5'b00000);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        r_ready_in = 5'b11101;
        empty      = 1'b0;
      end
      @(negedge clk);
      chk("bp_wr", 64'(wr_ready_out), 64'b00010);
      chk("bp_data", 64'(data_o), 64'(6'b110110) << BUS);
      chk("bp_req", 64'(r_req), 64'd0);
    end
    empty      = 1'b1;
    r_ready_in = 5'b00010;
    @(negedge clk);
    chk_zero("bp_release");
    @(negedge clk);
    chk_zero("bp_idle");

    // invalid packet is read then dropped
    send_pkt(6'b0_1_1111, 5'b11111);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_zero("drop");
    end

    // throughput: one packet every 4 cycles with the receiver always ready
    data_i     = 6'b1_1_0011;
    r_ready_in = 5'b11111;
    sb_q.push_back(ref_entry(6'b1_1_0011));
    sb_q.push_back(ref_entry(6'b1_1_0011));
    empty = 1'b0;
    wait_req();
    t1 = cyc;
    wait_req();
    t2 = cyc;
    empty = 1'b1;
    chk("tput_gap", 64'(t2 - t1), 64'd4);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk_zero("tput_end");

    // reset while a packet is held in SEND
    send_pkt(6'b1_1_0110, 5'b00000);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("mid_wr_before", 64'(wr_ready_out), 64'b00010);
    a_rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_rst");
    a_rst      = 1'b0;
    r_ready_in = 5'b11111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero("post_rst");
    end

    // normal operation resumes after reset
    send_pkt(6'b1_0_0101, 5'b11111);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk_zero("resume_end");
    chk("sb_left", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
